// File: rtl/fp_to_int_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_to_int_arbiter_pkg
// Shared definitions for the fp_to_int arbiter slice: FSM state encoding and
// the widths of the 13-bit floating-point operand and 8-bit integer result.
// No ports (package).
// ---------------------------------------------------------------------------
package fp_to_int_arbiter_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operand / result field widths
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int INT_W  = 8;

endpackage

// File: rtl/fp_to_int_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_to_int_arbiter_if
// Bundles the requester-facing bus of the fp_to_int arbiter.
//   req      : per-requester level request
//   sign_in  : per-requester sign bits, bit i belongs to requester i
//   exp_in   : per-requester exponents, slice [4i+3:4i]
//   frac_in  : per-requester fractions, slice [8i+7:8i]
//   gnt      : one-hot grant, high while the requester's operation is in flight
//   done     : one-cycle result-valid pulse
//   done_id  : index of the requester owning integ/uf/of
//   integ    : registered integer result
//   uf / of  : registered underflow / overflow flags
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fp_to_int_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  import fp_to_int_arbiter_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        sign_in;
  logic [EXP_W*N_REQ-1:0]  exp_in;
  logic [FRAC_W*N_REQ-1:0] frac_in;
  logic [N_REQ-1:0]        gnt;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [INT_W-1:0]        integ;
  logic                    uf;
  logic                    of;

  modport master (
    output req, sign_in, exp_in, frac_in,
    input  gnt, done, done_id, integ, uf, of
  );

  modport slave (
    input  req, sign_in, exp_in, frac_in,
    output gnt, done, done_id, integ, uf, of
  );

endinterface

// File: rtl/fp_to_int.sv
// ---------------------------------------------------------------------------
// fp_to_int
// Combinational converter from 13-bit FP (sign, 4-bit exponent, 8-bit
// fraction, value = 0.frac * 2^exp) to an 8-bit two's-complement integer.
//   sign  in  : operand sign
//   exp   in  : operand exponent
//   frac  in  : operand fraction
//   integ out : truncated integer, negated when sign is set
//   uf    out : exp == 0 (magnitude below one)
//   of    out : exp >= 8 (magnitude does not fit)
// ---------------------------------------------------------------------------
module fp_to_int
  import fp_to_int_arbiter_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output logic [INT_W-1:0]  integ,
  output logic              uf,
  output logic              of
);

  logic [INT_W-1:0] mag;

  // 0.frac * 2^exp truncated is the fraction shifted right by (8 - exp);
  // out-of-range exponents flag and force the integer to zero.
  always_comb begin
    mag   = '0;
    integ = '0;
    uf    = 1'b0;
    of    = 1'b0;
    if (exp == '0) begin
      uf = 1'b1;
    end else if (exp >= EXP_W'(8)) begin
      of = 1'b1;
    end else begin
      mag   = frac >> (EXP_W'(8) - exp);
      integ = sign ? (~mag + INT_W'(1)) : mag;
    end
  end

endmodule

// File: rtl/fp_to_int_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: finds the first set request bit scanning
// upward from ptr and wrapping from N_REQ-1 back to 0.
//   req   in  : request vector
//   ptr   in  : scan start index (always < N_REQ)
//   gnt   out : one-hot of the winner (zero when no request)
//   idx   out : winner index
//   valid out : any request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  int cand;

  // Walk N_REQ candidates starting at ptr; the first hit wins and later
  // hits are ignored through the valid flag.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = ID_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_to_int_arbiter.sv
// ---------------------------------------------------------------------------
// fp_to_int_arbiter
// Shares one fp_to_int converter between N_REQ requesters with round-robin
// arbitration. Operands of the winner are latched so the converter sees
// stable inputs; results are registered towards the requesters.
//   clk    in  : system clock
//   reset  in  : synchronous active-high reset
//   bus    slave modport of fp_to_int_arbiter_if (req/operands in,
//          gnt/done/done_id/integ/uf/of out)
// Optional build macro FP_TO_INT_ARB_STATS_EN adds saturating 16-bit
// counters:
//   conv_cnt out : completed conversions
//   uf_cnt   out : conversions that underflowed
//   of_cnt   out : conversions that overflowed
// ---------------------------------------------------------------------------
module fp_to_int_arbiter
  import fp_to_int_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  fp_to_int_arbiter_if.slave  bus
`ifdef FP_TO_INT_ARB_STATS_EN
  ,
  output logic [15:0]         conv_cnt,
  output logic [15:0]         uf_cnt,
  output logic [15:0]         of_cnt
`endif
);

  // Reject configurations whose index cannot address every requester
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("fp_to_int_arbiter: N_REQ must be in 2..8");
  end
  if ((1 << ID_W) < N_REQ) begin : g_bad_id_w
    $error("fp_to_int_arbiter: ID_W too narrow for N_REQ");
  end

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic               op_sign;
  logic [EXP_W-1:0]   op_exp;
  logic [FRAC_W-1:0]  op_frac;

  logic [N_REQ-1:0]   gnt_q;
  logic               done_q;
  logic [ID_W-1:0]    done_id_q;
  logic [INT_W-1:0]   integ_q;
  logic               uf_q;
  logic               of_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic [ID_W-1:0]    ptr_next;

  logic               sel_sign;
  logic [EXP_W-1:0]   sel_exp;
  logic [FRAC_W-1:0]  sel_frac;

  logic [INT_W-1:0]   conv_integ;
  logic               conv_uf;
  logic               conv_of;

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.integ   = integ_q;
  assign bus.uf      = uf_q;
  assign bus.of      = of_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  fp_to_int u_conv (
    .sign  (op_sign),
    .exp   (op_exp),
    .frac  (op_frac),
    .integ (conv_integ),
    .uf    (conv_uf),
    .of    (conv_of)
  );

  // Pointer moves one past the winner so it drops to lowest priority
  assign ptr_next = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

  // One-hot operand select driven by the arbiter's grant vector
  always_comb begin
    sel_sign = 1'b0;
    sel_exp  = '0;
    sel_frac = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_sign = bus.sign_in[i];
        sel_exp  = bus.exp_in[i*EXP_W +: EXP_W];
        sel_frac = bus.frac_in[i*FRAC_W +: FRAC_W];
      end
    end
  end

  // Sequencer: grant and latch in IDLE, capture the converter in CONV,
  // release the grant in RESP. Reset aborts any operation without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_sign   <= 1'b0;
      op_exp    <= '0;
      op_frac   <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      integ_q   <= '0;
      uf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            op_sign <= sel_sign;
            op_exp  <= sel_exp;
            op_frac <= sel_frac;
            gnt_q   <= arb_gnt;
            cur_id  <= arb_idx;
            rr_ptr  <= ptr_next;
            state   <= CONV;
          end
        end
        CONV: begin
          integ_q   <= conv_integ;
          uf_q      <= conv_uf;
          of_q      <= conv_of;
          done_id_q <= cur_id;
          done_q    <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          gnt_q  <= '0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef FP_TO_INT_ARB_STATS_EN
  // Counters step on the edge that raises done, saturating at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_cnt <= '0;
      uf_cnt   <= '0;
      of_cnt   <= '0;
    end else if (state == CONV) begin
      if (conv_cnt != 16'hFFFF) begin
        conv_cnt <= conv_cnt + 16'd1;
      end
      if (conv_uf && uf_cnt != 16'hFFFF) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
      if (conv_of && of_cnt != 16'hFFFF) begin
        of_cnt <= of_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
